// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipe_vr valid/ready pipeline.
package pipe_pkg;

    localparam int MIN_N = 1;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pipe_vr_stage.sv
// One pipeline slice: a valid flop plus a payload register that only loads on a real transfer.
module pipe_vr_stage #(
    parameter int           W    = 8,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         clr,
    input  logic         en,
    input  logic         v_nxt,
    input  logic         ld,
    input  logic [W-1:0] d_nxt,
    output logic         v,
    output logic [W-1:0] d
);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            v <= 1'b0;
        end else if (clr) begin
            v <= 1'b0;
        end else if (en) begin
            v <= v_nxt;
        end
    end

    // Payload holds across bubbles so the output does not toggle when empty.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            d <= INIT;
        end else if (ld) begin
            d <= d_nxt;
        end
    end

endmodule

// File: rtl/pipe_vr.sv
// N-stage valid/ready register pipeline with bubble collapse, synchronous flush and occupancy count.
module pipe_vr
    import pipe_pkg::*;
#(
    parameter int           W     = 8,
    parameter int           N     = 2,
    parameter logic [W-1:0] INIT  = '0,
    parameter int           CNT_W = cnt_w(N)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             flush,
    input  logic             in_vld,
    input  logic [W-1:0]     in_dat,
    output logic             in_rdy,
    output logic             out_vld,
    output logic [W-1:0]     out_dat,
    input  logic             out_rdy,
    output logic [CNT_W-1:0] occ
);

    if (N < MIN_N) begin : g_bad_n
        $error("pipe_vr: N must be at least 1");
    end

    logic [N-1:0] v;
    logic [N-1:0] free;
    logic [W-1:0] d [N];
    logic         in_xfer;
    logic         out_xfer;

    // A stage can take new contents when it is empty or its own contents move on.
    always_comb begin
        logic nxt_free;
        free     = '0;
        nxt_free = out_rdy;
        for (int i = N - 1; i >= 0; i--) begin
            free[i]  = ~v[i] | nxt_free;
            nxt_free = free[i];
        end
    end

    assign in_rdy   = free[0] & ~flush;
    assign in_xfer  = in_vld & in_rdy;
    assign out_xfer = v[N-1] & out_rdy & ~flush;
    assign out_vld  = v[N-1];
    assign out_dat  = d[N-1];

    for (genvar i = 0; i < N; i++) begin : g_stage
        logic         v_nxt;
        logic         ld;
        logic [W-1:0] d_nxt;

        if (i == 0) begin : g_head
            assign v_nxt = in_vld;
            assign d_nxt = in_dat;
        end else begin : g_body
            assign v_nxt = v[i-1];
            assign d_nxt = d[i-1];
        end

        assign ld = free[i] & v_nxt & ~flush;

        pipe_vr_stage #(
            .W    (W),
            .INIT (INIT)
        ) u_stage (
            .clk   (clk),
            .arst  (arst),
            .clr   (flush),
            .en    (free[i]),
            .v_nxt (v_nxt),
            .ld    (ld),
            .d_nxt (d_nxt),
            .v     (v[i]),
            .d     (d[i])
        );
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            occ <= '0;
        end else if (flush) begin
            occ <= '0;
        end else begin
            case ({in_xfer, out_xfer})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Producer must hold a refused beat unchanged until it is taken.
    a_in_hold: assert property (@(posedge clk) disable iff (arst)
        (in_vld && !in_rdy && !flush) |=> (in_vld && $stable(in_dat)));

    a_occ_pop: assert property (@(posedge clk) disable iff (arst)
        occ == CNT_W'($countones(v)));

endmodule

// File: doc/pipe_vr.md
Name: pipe_vr

Overview:
- Parametrised N-stage valid/ready pipeline register; the multi-stage, flow-controlled successor to the team's single-flop reset register.
- Carries a W-bit payload through N register slices with per-stage valid and bubble collapsing.
- Supports backpressure, synchronous flush and a live occupancy count.
- Sits between producer and consumer blocks where timing closure needs extra register slices and the downstream may stall.

Parameters:
- W, 8, payload width in bits (>= 1)
- N, 2, number of register stages (>= 1)
- INIT, '0, W-bit reset value of every stage data register
- CNT_W, $clog2(N+1), occupancy counter width (derived, not overridden)

Ports:
- clk  in  1  clock, all state on rising edge
- arst  in  1  asynchronous reset, active-high
- flush  in  1  synchronous clear of all stages
- in_vld  in  1  producer valid
- in_dat  in  W  producer payload
- in_rdy  out  1  pipe accepts in_dat this cycle
- out_vld  out  1  stage N-1 holds valid data
- out_dat  out  W  stage N-1 payload
- out_rdy  in  1  consumer accepts out_dat
- occ  out  CNT_W  number of valid stages, 0..N

Behaviour:
- Reset (arst=1, asynchronous assert): every stage valid=0, every data register=INIT, occ=0. Outputs: out_vld=0, out_dat=INIT, in_rdy=1 (combinational, derived from empty state). Deassertion is synchronous to clk; the team reset synchroniser guarantees this externally.
- State: v[i] and d[i] for i=0..N-1. Stage 0 is the input side; stage N-1 drives out_vld/out_dat.
- Advance chain (combinational):
  - adv[N-1] = v[N-1] & out_rdy
  - adv[i] = v[i] & (~v[i+1] | adv[i+1])
  - in_rdy = (~v[0] | adv[0]) & ~flush
- Stage i update (i>0):
  - If ~v[i] | adv[i]: v[i] <= v[i-1] & adv-eligible, i.e. stage i takes stage i-1 when v[i-1]=1.
  - d[i] loads d[i-1] only when v[i-1]=1 and stage i is free/advancing. Otherwise d[i] holds; no toggling on bubbles.
- Stage 0 loads in_dat when in_vld & in_rdy.
- Bubble collapse: a stalled stage N-1 does not block stages below it while empty stages exist between them.
- Latency: N cycles from accepted input to out_vld when unstalled. Throughput is 1 per cycle. in_rdy depends combinationally on out_rdy through the whole chain.
- Full: all v=1 and out_rdy=0 -> in_rdy=0, occ=N, all data held.
- Empty: out_vld=0 and out_dat holds its last value; consumers must qualify with out_vld.
- Simultaneous accept and emit when full with out_rdy=1: in_rdy=1, occ stays N.
- Flush=1: in_rdy=0, any in_vld is dropped, and out_rdy is ignored for state update. Next cycle all v=0 and occ=0; data registers hold.
- occ: registered, = popcount(v) in every cycle. Updated +1 on input transfer, -1 on output transfer, unchanged on both or neither, 0 after flush.
- Payload is never altered; there are no arithmetic width rules beyond occ saturating at N by construction.
- Protocol: in_dat must be stable while in_vld=1 & in_rdy=0. The producer must not drop in_vld before transfer (SVA assertion, disabled under arst).
- Reset mid-operation: all in-flight data is discarded immediately, with no partial transfer.

Decomposition:
- Package pipe_pkg: function cnt_w(N) returning $clog2(N+1), plus a localparam for the minimum legal N (1). No typedefs are needed, since the payload is opaque.
- Sub-module pipe_vr_stage: one valid flop plus a W-bit data register with async active-high reset to INIT, load enable and clear. Instantiated N times in a generate loop.
- pipe_vr holds the advance chain, the occ counter and the assertions.

Test Plan:
- Reset/idle, N=3, W=8, INIT=8'hA5: assert arst mid-cycle -> out_vld=0, out_dat=8'hA5, occ=0, in_rdy=1 immediately without a clock edge.
- Streaming: in_vld=1 with data 1,2,3,4,5 back-to-back, out_rdy=1 -> out_vld first high 3 cycles after first accept, outputs 1..5 consecutively, occ steady at 3.
- Backpressure/full: out_rdy=0, push 10,11,12 -> occ=3, in_rdy=0, out_dat=10. Release out_rdy for one cycle with in_vld=1, data 13 -> 10 emitted, 13 accepted, occ=3.
- Bubble collapse: push 20, idle 2 cycles, push 21, out_rdy=0 -> 21 advances to stage 1 behind 20 in stage 2, occ=2. Then out_rdy=1 -> 20 then 21 on consecutive cycles.
- Flush: occ=3 plus in_vld=1 with data 30 and flush=1 -> in_rdy=0, next cycle occ=0, out_vld=0, and 30 never appears at the output.
- Degenerate N=1: push 40 with out_rdy=0 -> in_rdy=0 next cycle. Then out_rdy=1 with in_vld=1, data 41 -> 40 emitted, 41 accepted in the same cycle.
